rsa_decrypt: RTL and testbench

RSA_DECRYPT -- requirements
Module: rsa_decrypt

---
 rtl/rsa_pkg.sv | 18 +
 rtl/mod_mult.sv | 66 ++++++
 rtl/rsa_decrypt.sv | 155 +++++++++++++++
 tb/tb_rsa_decrypt.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: operand widths, iteration count,
// cycle-counter width and the exponentiation controller state encoding.
package rsa_pkg;

   localparam int OP_W   = 16;
   localparam int ITER_N = 16;
   localparam int IDX_W  = $clog2(ITER_N);
   localparam int CYC_W  = 10;

   typedef enum logic [2:0] {
      IDLE,
      SQR,
      MUL,
      NEXT,
      DONE
   } state_t;

endpackage

// File: rtl/mod_mult.sv
// Interleaved shift-add modular multiplier: p = a*b mod n.
// A start pulse loads the operands (issue cycle), then 16 iterations walk b
// MSB first, so every product takes exactly 17 cycles regardless of values.
// done is high during the final iteration cycle; p holds the result afterwards.
// Operand a must already be reduced (a < n) for the result to stay below n.
module mod_mult
   import rsa_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   input  logic [OP_W-1:0] n,
   output logic [OP_W-1:0] p,
   output logic            done
);

   logic [OP_W-1:0]  a_q;
   logic [OP_W-1:0]  b_q;
   logic [OP_W-1:0]  n_q;
   logic [IDX_W-1:0] iter;
   logic             running;
   logic [OP_W:0]    dbl;
   logic [OP_W:0]    dbl_red;
   logic [OP_W:0]    sum;
   logic [OP_W-1:0]  p_next;

   // One iteration: double and reduce, then conditionally add a and reduce.
   // Both partial values stay below 2n, so 17 bits never overflow.
   always_comb begin
      dbl     = {p, 1'b0};
      dbl_red = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
      sum     = dbl_red + (b_q[OP_W-1] ? {1'b0, a_q} : '0);
      p_next  = OP_W'((sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum);
   end

   assign done = running && (iter == IDX_W'(ITER_N - 1));

   // Operand capture on issue, then 16 iterations shifting b left each cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         n_q     <= '0;
         p       <= '0;
         iter    <= '0;
         running <= 1'b0;
      end else if (start) begin
         a_q     <= a;
         b_q     <= b;
         n_q     <= n;
         p       <= '0;
         iter    <= '0;
         running <= 1'b1;
      end else if (running) begin
         p    <= p_next;
         b_q  <= {b_q[OP_W-2:0], 1'b0};
         iter <= iter + 1'b1;
         if (iter == IDX_W'(ITER_N - 1)) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption core: m = c^d mod n by left-to-right square-and-multiply
// over all 16 exponent bits. Products are chained with no idle gap: the
// first square is issued on the start edge, a MUL issues in its own first
// cycle, and NEXT issues the following square, so the total latency is
// 17*(16 + popcount(d)) + 1 cycles. The accumulator lives in the multiplier's
// result register, which is fed straight back as the next operand.
module rsa_decrypt
   import rsa_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  c,
   input  logic [OP_W-1:0]  d,
   input  logic [OP_W-1:0]  n,
   output logic [OP_W-1:0]  m,
   output logic             finish,
   output logic             busy,
   output logic             err,
   output logic [CYC_W-1:0] cycles
);

   state_t           state;
   logic [OP_W-1:0]  c_q;
   logic [OP_W-1:0]  d_q;
   logic [OP_W-1:0]  n_q;
   logic [IDX_W-1:0] idx;
   logic [CYC_W-1:0] cyc_cnt;
   logic             issued;
   logic             op_valid;
   logic             mm_start;
   logic [OP_W-1:0]  mm_a;
   logic [OP_W-1:0]  mm_b;
   logic [OP_W-1:0]  mm_n;
   logic [OP_W-1:0]  mm_p;
   logic             mm_done;

   assign op_valid = (n >= OP_W'(2)) && (c < n);

   // Multiplier issue control: the first square (1*1) uses the live inputs on
   // the start edge; later products reuse the previous result as operand a.
   always_comb begin
      mm_start = 1'b0;
      mm_a     = mm_p;
      mm_b     = mm_p;
      mm_n     = n_q;
      case (state)
         IDLE: begin
            mm_start = start && op_valid;
            mm_a     = OP_W'(1);
            mm_b     = OP_W'(1);
            mm_n     = n;
         end
         MUL: begin
            mm_start = !issued;
            mm_b     = c_q;
         end
         NEXT: begin
            mm_start = (idx != '0);
         end
         default: begin
            mm_start = 1'b0;
         end
      endcase
   end

   mod_mult u_mod_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mm_start),
      .a     (mm_a),
      .b     (mm_b),
      .n     (mm_n),
      .p     (mm_p),
      .done  (mm_done)
   );

   // Exponentiation controller with registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         n_q     <= '0;
         idx     <= '0;
         cyc_cnt <= '0;
         issued  <= 1'b0;
         m       <= '0;
         finish  <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
         cycles  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  c_q  <= c;
                  d_q  <= d;
                  n_q  <= n;
                  busy <= 1'b1;
                  if (op_valid) begin
                     state   <= SQR;
                     idx     <= IDX_W'(ITER_N - 1);
                     cyc_cnt <= CYC_W'(1);
                     issued  <= 1'b0;
                  end else begin
                     state  <= DONE;
                     finish <= 1'b1;
                     err    <= 1'b1;
                     m      <= '0;
                     cycles <= CYC_W'(1);
                  end
               end
            end
            SQR: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               if (mm_done) begin
                  state  <= d_q[idx] ? MUL : NEXT;
                  issued <= 1'b0;
               end
            end
            MUL: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               issued  <= 1'b1;
               if (mm_done) begin
                  state  <= NEXT;
                  issued <= 1'b0;
               end
            end
            NEXT: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               if (idx != '0) begin
                  idx   <= idx - 1'b1;
                  state <= SQR;
               end else begin
                  state  <= DONE;
                  finish <= 1'b1;
                  err    <= 1'b0;
                  m      <= mm_p;
                  cycles <= cyc_cnt + 1'b1;
               end
            end
            DONE: begin
               finish <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: expected results are queued when an
// operation is started and compared when the finish pulse appears.
module tb_rsa_decrypt;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] c;
   logic [15:0] d;
   logic [15:0] n;
   logic [15:0] m;
   logic        finish;
   logic        busy;
   logic        err;
   logic [9:0]  cycles;

   typedef struct {
      logic [15:0] m;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        expQ[$];
   int          assertCount;
   int          failCount;
   logic [15:0] prevM;

   rsa_decrypt dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .c      (c),
      .d      (d),
      .n      (n),
      .m      (m),
      .finish (finish),
      .busy   (busy),
      .err    (err),
      .cycles (cycles)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference exponentiation with plain wide arithmetic.
   function automatic logic [15:0] modExp(input logic [15:0] cc, input logic [15:0] dd,
                                          input logic [15:0] nn);
      longint r;
      r = 1;
      for (int i = 15; i >= 0; i--) begin
         r = (r * r) % nn;
         if (dd[i]) r = (r * cc) % nn;
      end
      return r[15:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one start pulse in the next cycle and queue the expected outcome.
   task automatic applyStimulus(input logic [15:0] cc, input logic [15:0] dd,
                                input logic [15:0] nn);
      exp_t e;
      @(negedge clk);
      checkOutput("idleBeforeStart", busy, 1'b0);
      start = 1'b1;
      c     = cc;
      d     = dd;
      n     = nn;
      if (nn >= 2 && cc < nn) begin
         e.m   = modExp(cc, dd, nn);
         e.err = 1'b0;
         e.lat = 17 * (16 + $countones(dd)) + 1;
      end else begin
         e.m   = '0;
         e.err = 1'b1;
         e.lat = 1;
      end
      expQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
      c     = $urandom;
      d     = $urandom;
      n     = $urandom;
   endtask

   // Wait for finish, optionally injecting a start that must be ignored.
   task automatic waitFinish(input string tag, input int injectAt, input logic [15:0] ic,
                             input logic [15:0] id, input logic [15:0] inn);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int k = 1; k <= 600 && !seen; k++) begin
         if (finish) begin
            seen = 1'b1;
            if (expQ.size() == 0) begin
               checkOutput({tag, "_unexpectedFinish"}, 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput({tag, "_m"}, m, e.m);
               checkOutput({tag, "_err"}, err, e.err);
               checkOutput({tag, "_cycles"}, cycles, e.lat);
               checkOutput({tag, "_latency"}, k, e.lat);
               checkOutput({tag, "_busyAtFinish"}, busy, 1'b1);
               prevM = e.m;
            end
         end else begin
            if (k == injectAt) begin
               checkOutput({tag, "_busyAtInject"}, busy, 1'b1);
               checkOutput({tag, "_mHeldWhileBusy"}, m, prevM);
               start = 1'b1;
               c     = ic;
               d     = id;
               n     = inn;
            end
            @(negedge clk);
            start = 1'b0;
         end
      end
      if (!seen) begin
         checkOutput({tag, "_finishTimeout"}, 0, 1);
         if (expQ.size() != 0) void'(expQ.pop_front());
      end
   endtask

   initial begin
      logic [15:0] rc;
      logic [15:0] rd;
      logic [15:0] rn;
      int          finishCount;
      assertCount = 0;
      failCount   = 0;
      prevM       = '0;

      // Reset with a start request present: it must be ignored.
      rst_n = 1'b0;
      start = 1'b1;
      c     = 16'd1394;
      d     = 16'd2011;
      n     = 16'd3127;
      repeat (3) @(negedge clk);
      start = 1'b0;
      checkOutput("resetBusy", busy, 1'b0);
      checkOutput("resetFinish", finish, 1'b0);
      checkOutput("resetErr", err, 1'b0);
      checkOutput("resetM", m, 16'd0);
      checkOutput("resetCycles", cycles, 10'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("startDuringResetIgnored", busy, 1'b0);

      // Reference vector and the exponent boundaries.
      applyStimulus(16'd1394, 16'd2011, 16'd3127);
      waitFinish("basic", 0, '0, '0, '0);
      applyStimulus(16'd1394, 16'd0, 16'd3127);
      waitFinish("dZero", 0, '0, '0, '0);
      applyStimulus(16'd1394, 16'd1, 16'd3127);
      waitFinish("dOne", 0, '0, '0, '0);
      applyStimulus(16'd5, 16'hFFFF, 16'd65535);
      waitFinish("dAllOnes", 0, '0, '0, '0);

      // Invalid operand sets.
      applyStimulus(16'd3127, 16'd2011, 16'd3127);
      waitFinish("cNotBelowN", 0, '0, '0, '0);
      applyStimulus(16'd0, 16'd7, 16'd1);
      waitFinish("nIsOne", 0, '0, '0, '0);

      // Start while busy is ignored, then a back-to-back start is accepted.
      applyStimulus(16'd1394, 16'd2011, 16'd3127);
      waitFinish("ignoreBusyStart", 50, 16'd5, 16'd3, 16'd7);
      applyStimulus(16'd5, 16'd3, 16'd7);
      waitFinish("backToBack", 0, '0, '0, '0);

      // Reset in the middle of an operation aborts it without a finish.
      applyStimulus(16'd1394, 16'd2011, 16'd3127);
      finishCount = 0;
      for (int i = 0; i < 100; i++) begin
         if (finish) finishCount++;
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      expQ.delete();
      checkOutput("midResetBusy", busy, 1'b0);
      checkOutput("midResetM", m, 16'd0);
      checkOutput("midResetFinish", finish, 1'b0);
      for (int i = 0; i < 450; i++) begin
         if (finish) finishCount++;
         @(negedge clk);
      end
      checkOutput("noFinishAfterAbort", finishCount, 0);
      prevM = '0;
      applyStimulus(16'd1394, 16'd2011, 16'd3127);
      waitFinish("afterReset", 0, '0, '0, '0);

      // Random valid vectors against the reference model.
      for (int i = 0; i < 200; i++) begin
         rn = 16'($urandom_range(65535, 2));
         rc = 16'($urandom_range(int'(rn) - 1, 0));
         rd = (i % 4 == 0) ? 16'($urandom) : 16'($urandom & $urandom);
         applyStimulus(rc, rd, rn);
         waitFinish("random", 0, '0, '0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
